// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler sharing one UART sender between two FIFO-buffered byte requesters.
// Define UART_TX_SCHED_TIMEOUT_EN to add a per-byte watchdog that abandons a stuck frame.
module uart_tx_sched #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd12000
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_status,
    output logic       grant_id,
    output logic       busy,
    output logic       err_timeout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    logic [7:0]       mem_q    [2][FIFO_DEPTH];
    logic [7:0]       req_data [2];
    logic [1:0]       req_valid;
    logic [PTR_W-1:0] wptr_q [2];
    logic [PTR_W-1:0] wptr_d [2];
    logic [PTR_W-1:0] rptr_q [2];
    logic [PTR_W-1:0] rptr_d [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       non_empty;
    logic             gnt;

    logic [1:0] state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic       tx_en_q, tx_en_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       grant_q, grant_d;
    logic       busy_q, busy_d;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // Ready looks only at the registered count, so a full FIFO refuses a push even while being popped.
    assign req0_ready = (cnt_q[0] != CNT_FULL);
    assign req1_ready = (cnt_q[1] != CNT_FULL);
    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    assign err_timeout = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign err_timeout        = 1'b0;
`endif

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            push[c]      = req_valid[c] && (cnt_q[c] != CNT_FULL);
            non_empty[c] = (cnt_q[c] != '0);
        end
        // Round-robin only decides ties; a lone non-empty FIFO is always served.
        gnt       = (non_empty[0] && non_empty[1]) ? ~rr_last_q : non_empty[1];
        pop       = '0;
        state_d   = state_q;
        rr_last_d = rr_last_q;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;

        case (state_q)
            ST_IDLE: begin
                if (non_empty != 2'b00) begin
                    pop[gnt]  = 1'b1;
                    tx_data_d = mem_q[gnt][rptr_q[gnt]];
                    grant_d   = gnt;
                    tx_en_d   = 1'b1;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (tx_status) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_status) begin
                    tx_en_d   = 1'b0;
                    rr_last_d = grant_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                tx_en_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

`ifdef UART_TX_SCHED_TIMEOUT_EN
        err_d = 1'b0;
        tmo_d = tmo_q + 16'd1;
        if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
            // The byte in flight is abandoned; the sender is never told.
            tmo_d     = '0;
            err_d     = 1'b1;
            tx_en_d   = 1'b0;
            rr_last_d = grant_q;
            state_d   = ST_IDLE;
        end
`endif

        busy_d = (state_d != ST_IDLE);
        for (int c = 0; c < 2; c++) begin
            wptr_d[c] = wptr_q[c] + PTR_W'(push[c]);
            rptr_d[c] = rptr_q[c] + PTR_W'(pop[c]);
            cnt_d[c]  = cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
        end
    end

    always_ff @(posedge sysclk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c]] <= req_data[c];
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            for (int c = 0; c < 2; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-based reference model of the two FIFOs and round-robin order,
// a simple UART sender model, directed scenarios and a randomized traffic run.
module tb_uart_tx_sched;
    localparam int DEPTH = 4;
    localparam int TMO   = 50;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       tx_status = 1'b0;
    logic       req0_ready, req1_ready, tx_en, grant_id, busy, err_timeout;
    logic [7:0] tx_data;

    always #5 sysclk = ~sysclk;

    uart_tx_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(16'(TMO))) dut (
        .sysclk(sysclk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_en(tx_en), .tx_data(tx_data), .tx_status(tx_status),
        .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: per-channel byte queues plus the channel served last.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] launched[$];
    logic       rr_m = 1'b1;
    logic       prev_ten = 1'b0;
    logic       rdy0_m = 1'b1;
    logic       rdy1_m = 1'b1;
    logic [7:0] held_data = 8'h00;
    logic       held_grant = 1'b0;
    int         cyc = 0;
    int         launch_cyc = -1000;
    int         n_err = 0;
    bit         tmo_mode = 0;

    // Sender model state.
    int snd_delay = 3;
    int snd_hold = 20;
    int snd_cnt = 0;
    int snd_left = 0;
    bit snd_never = 0;
    bit snd_done = 0;
    bit snd_fell = 0;
    bit snd_rand = 0;

    task automatic step();
        logic       rst_edge, v0, v1, ch;
        logic [7:0] d0, d1, eb;
        rst_edge = reset;
        v0 = req0_valid; d0 = req0_data;
        v1 = req1_valid; d1 = req1_data;
        @(negedge sysclk);
        cyc++;
        if (rst_edge) begin
            q0.delete();
            q1.delete();
            rr_m = 1'b1;
            chk("rst_tx_en", tx_en, 0);
            chk("rst_tx_data", tx_data, 8'h00);
            chk("rst_grant", grant_id, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err_timeout, 0);
            chk("rst_ready0", req0_ready, 1);
            chk("rst_ready1", req1_ready, 1);
            prev_ten = 1'b0;
            rdy0_m = 1'b1;
            rdy1_m = 1'b1;
            tx_status = 1'b0;
            snd_cnt = 0;
            snd_done = 0;
            snd_fell = 0;
        end else begin
            if (snd_fell) chk("txen_after_status_fall", tx_en, 0);
            snd_fell = 0;
            if (tx_en && !prev_ten) begin
                if (q0.size() == 0 && q1.size() == 0) begin
                    chk("spurious_launch", tx_en, 0);
                    held_data = tx_data;
                    held_grant = grant_id;
                end else begin
                    ch = (q0.size() != 0 && q1.size() != 0) ? ~rr_m : (q0.size() == 0);
                    eb = ch ? q1.pop_front() : q0.pop_front();
                    chk("launch_grant", grant_id, ch);
                    chk("launch_data", tx_data, eb);
                    rr_m = ch;
                    held_data = eb;
                    held_grant = ch;
                end
                launched.push_back(tx_data);
                launch_cyc = cyc;
            end else if (tx_en) begin
                chk("hold_data", tx_data, held_data);
                chk("hold_grant", grant_id, held_grant);
            end else if (!prev_ten) begin
                chk("idle_gap", q0.size() + q1.size(), 0);
            end
            chk("busy", busy, tx_en);
            chk("err_timeout", err_timeout, tmo_mode && (cyc == launch_cyc + TMO));
            if (err_timeout) n_err++;
            if (v0 && rdy0_m) q0.push_back(d0);
            if (v1 && rdy1_m) q1.push_back(d1);
            rdy0_m = (q0.size() != DEPTH);
            rdy1_m = (q1.size() != DEPTH);
            chk("ready0", req0_ready, rdy0_m);
            chk("ready1", req1_ready, rdy1_m);
            prev_ten = tx_en;
            if (!tx_en) begin
                snd_cnt = 0;
                snd_done = 0;
                tx_status = 1'b0;
                if (snd_rand) begin
                    snd_delay = $urandom_range(1, 4);
                    snd_hold = $urandom_range(1, 8);
                end
            end else if (tx_status) begin
                snd_left--;
                if (snd_left <= 0) begin
                    tx_status = 1'b0;
                    snd_fell = 1;
                    snd_done = 1;
                end
            end else if (!snd_done && !snd_never) begin
                snd_cnt++;
                if (snd_cnt >= snd_delay) begin
                    tx_status = 1'b1;
                    snd_left = snd_hold;
                end
            end
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        launched.delete();
    endtask

    task automatic drain(input int bound);
        int i = 0;
        while ((busy || q0.size() != 0 || q1.size() != 0) && i < bound) begin
            step();
            i++;
        end
        chk("drain_done", busy + q0.size() + q1.size(), 0);
    endtask

    initial begin
        logic [7:0] ord2 [6] = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13};
        int n, i, ee;

        // Single byte latency
        do_reset();
        snd_delay = 3; snd_hold = 20;
        req0_valid = 1'b1; req0_data = 8'h41;
        step();
        req0_valid = 1'b0;
        chk("t1_txen_push_edge", tx_en, 0);
        step();
        chk("t1_txen", tx_en, 1);
        chk("t1_data", tx_data, 8'h41);
        chk("t1_grant", grant_id, 0);
        drain(100);
        chk("t1_busy_end", busy, 0);

        // Preloaded round-robin order
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req0_data = 8'(k + 1);
            req1_valid = 1'b1; req1_data = 8'(8'h11 + k);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain(400);
        chk("t2_count", launched.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < launched.size()) chk("t2_order", launched[k], ord2[k]);
        end

        // Fill ch1 while the sender is busy
        do_reset();
        snd_delay = 3; snd_hold = 30;
        req0_valid = 1'b1; req0_data = 8'hA0;
        step();
        req0_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            req1_valid = 1'b1; req1_data = 8'(8'hB0 + k);
            step();
        end
        chk("t3_full", req1_ready, 0);
        req1_data = 8'hEE;
        step();
        req1_valid = 1'b0;
        chk("t3_full_after_ee", req1_ready, 0);
        n = launched.size();
        i = 0;
        while (launched.size() == n && i < 100) begin
            step();
            i++;
        end
        chk("t3_pop_grant", grant_id, 1);
        chk("t3_ready_after_pop", req1_ready, 1);
        drain(400);
        ee = 0;
        foreach (launched[k]) if (launched[k] == 8'hEE) ee++;
        chk("t3_no_ee", ee, 0);
        chk("t3_count", launched.size(), 5);

        // Simultaneous push and pop on ch0 at count 2
        do_reset();
        snd_delay = 3; snd_hold = 10;
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req0_data = 8'(8'hC1 + k);
            step();
        end
        req0_valid = 1'b0;
        i = 0;
        while (tx_en && i < 100) begin
            step();
            i++;
        end
        req0_valid = 1'b1; req0_data = 8'hC4;
        step();
        chk("t4_launch", tx_en, 1);
        chk("t4_data", tx_data, 8'hC2);
        req0_data = 8'hC5;
        step();
        chk("t4_ready_cnt3", req0_ready, 1);
        req0_data = 8'hC6;
        step();
        req0_valid = 1'b0;
        chk("t4_ready_cnt4", req0_ready, 0);
        drain(400);
        chk("t4_count", launched.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < launched.size()) chk("t4_order", launched[k], 8'(8'hC1 + k));
        end

        // Reset during WAIT_DONE with bytes queued
        do_reset();
        snd_delay = 3; snd_hold = 20;
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req0_data = 8'(8'hD1 + k);
            step();
        end
        req0_valid = 1'b0;
        i = 0;
        while (!tx_status && i < 50) begin
            step();
            i++;
        end
        step();
        n = launched.size();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_tx_en", tx_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready0", req0_ready, 1);
        chk("t5_ready1", req1_ready, 1);
        repeat (40) step();
        chk("t5_no_tx", launched.size(), n);

        // Randomized traffic against the model
        do_reset();
        snd_rand = 1;
        for (int k = 0; k < 800; k++) begin
            req0_valid = ($urandom_range(0, 3) == 0);
            req0_data = 8'($urandom);
            req1_valid = ($urandom_range(0, 3) == 0);
            req1_data = 8'($urandom);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain(2000);
        snd_rand = 0;

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Sender never responds: each byte is abandoned after TMO cycles
        do_reset();
        tmo_mode = 1;
        snd_never = 1;
        n_err = 0;
        req0_valid = 1'b1; req0_data = 8'hE1;
        step();
        req0_data = 8'hE2;
        step();
        req0_valid = 1'b0;
        repeat (110) step();
        chk("t7_err_count", n_err, 2);
        chk("t7_launches", launched.size(), 2);
        tmo_mode = 0;
        snd_never = 0;
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
